// File: rtl/dm_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The ARB_EXT state only exists in builds with DM_ARB_STARVE_GUARD_EN defined.
package dm_arbiter_pkg;

  typedef enum logic {
    ARB_CPU = 1'b0,
    ARB_EXT = 1'b1
  } arb_state_e;

  localparam logic [31:0] DM_UPPER         = 32'h0000_3000;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned CNT_W            = 3;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dm_req_t;

  // Ext accesses at or above the data-memory window are rejected.
  function automatic logic is_oob(input logic [31:0] addr);
    return addr >= DM_UPPER;
  endfunction

endpackage

// File: rtl/dm_arb_starve_cnt.sv
// Counts consecutive cycles in which the ext requester is denied and
// raises force_ext_c on the denial that reaches the limit.
module dm_arb_starve_cnt
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic ext_req,
  input  logic ext_gnt,
  output logic force_ext_c
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;
  logic             denied;
  logic             at_last;

  assign denied      = ext_req & ~ext_gnt;
  assign at_last     = (cnt == LAST);
  assign force_ext_c = denied & at_last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (denied) begin
      cnt <= at_last ? '0 : cnt + CNT_W'(1);
    end else if (ext_gnt) begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter between the CPU Mem stage and an external requester.
// DM_ARB_STARVE_GUARD_EN adds a one-cycle forced ext grant after repeated denials.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_be,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  input  logic [3:0]  ext_be,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  output logic        ext_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  input  logic [31:0] dm_rdata
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
    $error("dm_arbiter: STARVE_LIMIT must be in 1..7");
  end

  logic        in_ext;
  logic        ext_sel;
  logic        ext_oob;
  dm_req_t     dm_req;
  logic        rvalid_q;
  logic        err_q;
  logic [31:0] rdata_q;

  assign ext_oob = is_oob(ext_addr);

`ifdef DM_ARB_STARVE_GUARD_EN
  arb_state_e state;
  arb_state_e state_next;
  logic       force_ext_c;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ARB_CPU;
    end else begin
      state <= state_next;
    end
  end

  // ARB_EXT is a single-cycle excursion; every other path lands in ARB_CPU.
  always_comb begin
    state_next = ARB_CPU;
    if (force_ext_c) begin
      state_next = ARB_EXT;
    end
  end

  assign in_ext = (state == ARB_EXT);

  dm_arb_starve_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk        (clk),
    .reset      (reset),
    .ext_req    (ext_req),
    .ext_gnt    (ext_gnt),
    .force_ext_c(force_ext_c)
  );
`else
  assign in_ext = 1'b0;
`endif

  // Grant selection and DM port mux; everything is held idle in reset.
  always_comb begin
    ext_sel = 1'b0;
    dm_req  = '{we: 1'b0, addr: cpu_addr, wdata: cpu_wdata, be: 4'h0};
    if (reset) begin
      ext_sel = ext_req & (in_ext | ~cpu_req);
      if (ext_sel) begin
        dm_req = '{we: ext_we & ~ext_oob, addr: ext_addr, wdata: ext_wdata, be: ext_be};
      end else if (cpu_req) begin
        dm_req = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata, be: cpu_be};
      end
    end
  end

  assign ext_gnt   = ext_sel;
  assign cpu_stall = ext_sel & cpu_req;
  assign dm_addr   = dm_req.addr;
  assign dm_wdata  = dm_req.wdata;
  assign dm_we     = dm_req.we;
  assign dm_be     = dm_req.be;
  assign cpu_rdata = dm_rdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      rvalid_q <= ext_gnt;
      err_q    <= ext_gnt & ext_oob;
      if (ext_gnt && !ext_we && !ext_oob) begin
        rdata_q <= dm_rdata;
      end
    end
  end

  // Reset in the response cycle cancels a pending response pulse.
  assign ext_rvalid = rvalid_q & reset;
  assign ext_err    = err_q & reset;
  assign ext_rdata  = rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed steps then constrained-random
// traffic, all compared against a behavioural arbitration/memory model.
module tb_dm_arbiter;

  localparam int LIMIT = 4;
`ifdef DM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata;
  logic [3:0]  ext_be;
  logic        ext_gnt, ext_rvalid, ext_err;
  logic [31:0] ext_rdata;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_we;
  logic [3:0]  dm_be;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_be(ext_be), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .ext_err(ext_err), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we),
    .dm_be(dm_be), .dm_rdata(dm_rdata)
  );

  // Environment memory seen by the DUT, indexed by word address bits [9:2].
  logic [31:0] tb_mem [256];
  assign dm_rdata = tb_mem[dm_addr[9:2]];

  always @(posedge clk) begin
    if (dm_we === 1'b1) begin
      for (int b = 0; b < 4; b++) begin
        if (dm_be[b]) tb_mem[dm_addr[9:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [256];
  int          m_streak;
  bit          m_force;
  bit          m_rvalid, m_err;
  logic [31:0] m_rdata;
  bit          last_win;
  bit          e_win, e_oob, e_we;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_be;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected outputs for the current cycle from the arbitration rules.
  task automatic check_model();
    bit force_now;
    force_now = GUARD && m_force;
    e_win = reset && ext_req && (!cpu_req || force_now);
    e_oob = (ext_addr >= 32'h0000_3000);
    e_addr  = e_win ? ext_addr  : cpu_addr;
    e_wdata = e_win ? ext_wdata : cpu_wdata;
    e_we = e_win ? (ext_we && !e_oob) : (reset && cpu_req && cpu_we);
    e_be = e_win ? ext_be : ((reset && cpu_req) ? cpu_be : 4'h0);
    chk("ext_gnt",    32'(ext_gnt),   32'(e_win));
    chk("cpu_stall",  32'(cpu_stall), 32'(e_win && cpu_req));
    chk("dm_we",      32'(dm_we),     32'(e_we));
    chk("dm_be",      32'(dm_be),     32'(e_be));
    if (reset) begin
      chk("dm_addr",   dm_addr,   e_addr);
      chk("dm_wdata",  dm_wdata,  e_wdata);
      chk("cpu_rdata", cpu_rdata, ref_mem[e_addr[9:2]]);
    end
    chk("ext_rvalid", 32'(ext_rvalid), 32'(m_rvalid && reset));
    chk("ext_err",    32'(ext_err),    32'(m_err && reset));
    chk("ext_rdata",  ext_rdata, m_rdata);
  endtask

  task automatic advance();
    @(posedge clk);
    if (!reset) begin
      m_streak = 0; m_force = 0; m_rvalid = 0; m_err = 0; m_rdata = 32'h0;
    end else begin
      if (e_win && !ext_we && !e_oob) m_rdata = ref_mem[e_addr[9:2]];
      if (e_we) begin
        for (int b = 0; b < 4; b++) begin
          if (e_be[b]) ref_mem[e_addr[9:2]][8*b +: 8] = e_wdata[8*b +: 8];
        end
      end
      m_rvalid = e_win;
      m_err    = e_win && e_oob;
      m_force  = 0;
      if (ext_req && !e_win) begin
        m_streak++;
        if (m_streak == LIMIT) begin
          m_streak = 0;
          m_force  = 1;
        end
      end else if (e_win) begin
        m_streak = 0;
      end
    end
    last_win = e_win;
    #1;
  endtask

  task automatic step();
    #3;
    check_model();
    advance();
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_be = be;
  endtask

  task automatic set_ext(input bit req, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    ext_req = req; ext_we = we; ext_addr = a; ext_wdata = d; ext_be = be;
  endtask

  initial begin
    bit pending;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 32'h0;
      ref_mem[i] = 32'h0;
    end
    m_streak = 0; m_force = 0; m_rvalid = 0; m_err = 0; m_rdata = 32'h0;
    last_win = 0; pending = 0;

    // Reset with both requesters active: nothing may reach the DM.
    reset = 1'b0;
    set_cpu(1, 1, 32'h20, 32'h1111_2222, 4'hF);
    set_ext(1, 1, 32'h24, 32'h3333_4444, 4'hF);
    @(posedge clk); #1;
    advance();
    step();

    // CPU write, then ext read of the same word.
    reset = 1'b1;
    set_ext(0, 0, 32'h0, 32'h0, 4'h0);
    set_cpu(1, 1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    #3;
    chk("cpu_wr_dm_we",   32'(dm_we),     32'd1);
    chk("cpu_wr_dm_addr", dm_addr,        32'h10);
    chk("cpu_wr_stall",   32'(cpu_stall), 32'd0);
    check_model();
    advance();

    set_cpu(0, 0, 32'h0, 32'h0, 4'h0);
    set_ext(1, 0, 32'h10, 32'h0, 4'hF);
    #3;
    chk("ext_rd_gnt", 32'(ext_gnt), 32'd1);
    check_model();
    advance();
    set_ext(0, 0, 32'h0, 32'h0, 4'h0);
    #3;
    chk("ext_rd_rvalid", 32'(ext_rvalid), 32'd1);
    chk("ext_rd_rdata",  ext_rdata,       32'hDEAD_BEEF);
    check_model();
    advance();

    // Both requesters held: forced grant every LIMIT+1 cycles only with the guard.
    set_cpu(1, 0, 32'h40, 32'h0, 4'hF);
    set_ext(1, 0, 32'h10, 32'h0, 4'hF);
    for (int i = 0; i < 20; i++) begin
      #3;
      chk("starve_gnt",   32'(ext_gnt),   32'(GUARD && (i % 5 == 4)));
      chk("starve_stall", 32'(cpu_stall), 32'(GUARD && (i % 5 == 4)));
      check_model();
      advance();
    end
    set_cpu(0, 0, 32'h0, 32'h0, 4'h0);
    step();

    // Out-of-range ext write is granted but blocked, and reports an error.
    set_ext(1, 1, 32'h3004, 32'hCAFE_F00D, 4'hF);
    #3;
    chk("oob_gnt",   32'(ext_gnt), 32'd1);
    chk("oob_dm_we", 32'(dm_we),   32'd0);
    check_model();
    advance();
    set_ext(0, 0, 32'h0, 32'h0, 4'h0);
    #3;
    chk("oob_err",    32'(ext_err),    32'd1);
    chk("oob_rvalid", 32'(ext_rvalid), 32'd1);
    check_model();
    advance();

    // Reset in the response cycle cancels the pulse and returns to CPU priority.
    set_ext(1, 0, 32'h10, 32'h0, 4'hF);
    step();
    reset = 1'b0;
    set_ext(0, 0, 32'h0, 32'h0, 4'h0);
    #3;
    chk("rst_rvalid", 32'(ext_rvalid), 32'd0);
    check_model();
    advance();
    reset = 1'b1;
    set_cpu(1, 0, 32'h40, 32'h0, 4'hF);
    set_ext(1, 0, 32'h10, 32'h0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      #3;
      chk("post_rst_gnt", 32'(ext_gnt), 32'(GUARD && i == 4));
      check_model();
      advance();
    end
    set_cpu(0, 0, 32'h0, 32'h0, 4'h0);
    step();
    set_ext(0, 0, 32'h0, 32'h0, 4'h0);
    pending = 0;

    // Random traffic; ext fields stay stable from request until grant.
    for (int i = 0; i < 400; i++) begin
      if (!pending && $urandom_range(0, 2) == 0) begin
        pending = 1;
        ext_we    = 1'($urandom_range(0, 1));
        ext_addr  = ($urandom_range(0, 7) == 0) ? 32'h3000 + 32'($urandom_range(0, 255) << 2)
                                                : 32'($urandom_range(0, 255) << 2);
        ext_wdata = $urandom;
        ext_be    = 4'($urandom_range(0, 15));
      end
      ext_req = pending;
      set_cpu(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 255) << 2), $urandom, 4'($urandom_range(0, 15)));
      step();
      if (last_win) pending = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
